sim_harness_ctrl: RTL and testbench

Synthesizable test-harness controller that sits beside `riscv_core`, on the same clock, and replaces the behavioural test-completion logic with a reusable block. It holds the core in reset for a programmable number of cycles and decodes `tohost` writes into pass or fail. On pass it halts the core and streams a register-file signature out over a valid/ready port. An optional watchdog terminates runs that never report.

---
 rtl/sim_harness_pkg.sv | 21 ++
 rtl/sim_harness_ctrl_watchdog.sv | 40 ++++
 rtl/sim_harness_ctrl.sv | 133 +++++++++++++
 tb/tb_sim_harness_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_harness_pkg.sv
// Shared types and constants for sim_harness_ctrl.
// Optional watchdog is built when SIM_HARNESS_WATCHDOG_EN is defined.
package sim_harness_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    DUMP_LOAD,
    DUMP_SEND,
    DONE
  } state_t;

  localparam int TOHOST_PASS_BIT   = 0;
  localparam int TOHOST_CODE_SHIFT = 1;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_MAX_CYCLES = 500000;

endpackage

// File: rtl/sim_harness_ctrl_watchdog.sv
// harness_watchdog: RUN-state cycle counter with terminal count.
// Counter exists only when SIM_HARNESS_WATCHDOG_EN is defined.
module harness_watchdog
  import sim_harness_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

`ifdef SIM_HARNESS_WATCHDOG_EN
  localparam int CW =
    (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(MAX_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Holds at the terminal count, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != TERM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == TERM);
`else
  logic unused_wd;
  assign unused_wd =
    &{1'b0, clk, rst, en, clr, (MAX_CYCLES > 0)};
  assign tc = 1'b0;
`endif

endmodule

// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl: core reset hold, tohost decode, signature dump.
// Watchdog timeout is enabled by SIM_HARNESS_WATCHDOG_EN.
module sim_harness_ctrl
  import sim_harness_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_write_enable,
  input  logic [XLEN-1:0]             host_data_out,
  output logic                        core_rst,
  output logic                        core_halt,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]             rf_rd_data,
  output logic                        sig_valid,
  input  logic                        sig_ready,
  output logic [XLEN-1:0]             sig_data,
  output logic [$clog2(NUM_REGS)-1:0] sig_index,
  output logic                        done,
  output logic                        pass,
  output logic [XLEN-2:0]             fail_code,
  output logic                        timed_out
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [AW-1:0] LAST =
    AW'(NUM_REGS - 1);
  localparam logic [HW-1:0] HOLD_END =
    HW'(RST_CYCLES - 1);

  state_t state, state_n;

  logic [HW-1:0] hold_cnt;
  logic [AW-1:0] idx;
  logic          pass_q;
  logic          tmo_q;
  logic          wd_tc;
  logic          wr;
  logic          is_pass;
  logic          hs;

  assign wr      = host_write_enable && (state == RUN);
  assign is_pass = host_data_out[TOHOST_PASS_BIT];
  assign hs      = (state == DUMP_SEND) && sig_ready;

  harness_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_wd (
    .clk(clk),
    .rst(rst),
    .en (state == RUN),
    .clr(state != RUN),
    .tc (wd_tc)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HOLD_END) state_n = RUN;
      end
      RUN: begin
        // A tohost write beats a same-cycle timeout.
        unique case (1'b1)
          wr && is_pass:  state_n = DUMP_LOAD;
          wr && !is_pass: state_n = DONE;
          !wr && wd_tc:   state_n = DONE;
          default:        state_n = RUN;
        endcase
      end
      DUMP_LOAD: state_n = DUMP_SEND;
      DUMP_SEND: begin
        if (sig_ready) begin
          state_n = (idx == LAST) ? DONE : DUMP_LOAD;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      idx       <= '0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
      fail_code <= '0;
      sig_data  <= '0;
      sig_index <= '0;
    end else begin
      state <= state_n;
      if (state == HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (wr && is_pass) begin
        pass_q <= 1'b1;
        idx    <= '0;
      end
      if (wr && !is_pass) begin
        fail_code <=
          host_data_out[XLEN-1:TOHOST_CODE_SHIFT];
      end
      if ((state == RUN) && !wr && wd_tc) begin
        tmo_q <= 1'b1;
      end
      if (state == DUMP_LOAD) begin
        sig_data  <= rf_rd_data;
        sig_index <= idx;
      end
      if (hs && (idx != LAST)) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign core_rst   = (state == HOLD);
  assign core_halt  = (state == DUMP_LOAD) ||
                      (state == DUMP_SEND) ||
                      (state == DONE);
  assign rf_rd_addr = idx;
  assign sig_valid  = (state == DUMP_SEND);
  assign done       = (state == DONE);
  assign pass       = pass_q;
  assign timed_out  = tmo_q;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Self-checking bench for sim_harness_ctrl.
// Watchdog checks depend on SIM_HARNESS_WATCHDOG_EN.
module tb_sim_harness_ctrl;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int RC   = 2;
  localparam int MAXC = 100;
  localparam int AW   = $clog2(NR);

  logic            clk;
  logic            rst;
  logic            host_write_enable;
  logic [XLEN-1:0] host_data_out;
  logic            core_rst;
  logic            core_halt;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic            sig_valid;
  logic            sig_ready;
  logic [XLEN-1:0] sig_data;
  logic [AW-1:0]   sig_index;
  logic            done;
  logic            pass;
  logic [XLEN-2:0] fail_code;
  logic            timed_out;

  logic [XLEN-1:0] rf [NR];
  assign rf_rd_data = rf[rf_rd_addr];

  int checks = 0;
  int failures = 0;

  sim_harness_ctrl #(
    .XLEN(XLEN), .NUM_REGS(NR),
    .RST_CYCLES(RC), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst),
    .host_write_enable(host_write_enable),
    .host_data_out(host_data_out),
    .core_rst(core_rst), .core_halt(core_halt),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .sig_valid(sig_valid), .sig_ready(sig_ready),
    .sig_data(sig_data), .sig_index(sig_index),
    .done(done), .pass(pass),
    .fail_code(fail_code), .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag,
                           input bit exp_rst);
    chk({tag, ".core_rst"}, core_rst, exp_rst);
    chk({tag, ".core_halt"}, core_halt, 0);
    chk({tag, ".rf_rd_addr"}, rf_rd_addr, 0);
    chk({tag, ".sig_valid"}, sig_valid, 0);
    chk({tag, ".sig_data"}, sig_data, 0);
    chk({tag, ".sig_index"}, sig_index, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".fail_code"}, fail_code, 0);
    chk({tag, ".timed_out"}, timed_out, 0);
  endtask

  // Leaves the DUT in its first RUN cycle.
  task automatic do_reset();
    rst = 1'b1;
    host_write_enable = 1'b0;
    sig_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (RC) tick();
  endtask

  task automatic fill_rf(input bit pattern);
    for (int i = 0; i < NR; i++)
      rf[i] = pattern ? (32'hA000_0000 + i) : $urandom;
  endtask

  // Consumes the dump; expected words come from the rf contents.
  // mode 0: ready=1, 1: random ready, 2: stall word 7 for 5.
  task automatic run_dump(input int mode);
    int n = 0;
    int stall = 0;
    int waits = 0;
    int cyc = 0;
    bit waiting = 0;
    logic [XLEN-1:0] hd = '0;
    logic [AW-1:0] hi = '0;
    while (!done && cyc < 2000) begin
      if (mode == 0) sig_ready = 1'b1;
      else if (mode == 1) sig_ready = 1'($urandom_range(0, 1));
      else sig_ready = !(n == 7 && stall < 5);
      if (sig_valid) begin
        if (waiting) begin
          chk("stall.sig_data", sig_data, hd);
          chk("stall.sig_index", sig_index, hi);
        end
        if (sig_ready) begin
          chk($sformatf("word%0d.data", n), sig_data, rf[n]);
          chk($sformatf("word%0d.index", n), sig_index, n);
          n++;
          waiting = 0;
        end else begin
          if (mode == 2) stall++;
          waits++;
          waiting = 1;
          hd = sig_data;
          hi = sig_index;
        end
      end
      tick();
      cyc++;
    end
    chk("dump.words", n, NR);
    chk("dump.cycles", cyc, 2 * NR + waits);
    chk("dump.done", done, 1);
    chk("dump.pass", pass, 1);
    chk("dump.timed_out", timed_out, 0);
    chk("dump.sig_valid", sig_valid, 0);
    sig_ready = 1'b0;
  endtask

  typedef struct {
    logic [XLEN-1:0] data;
    bit              exp_done;
    bit              exp_pass;
    logic [XLEN-2:0] exp_code;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cnt;
    logic [XLEN-1:0] d;
    logic [XLEN-2:0] code;

    vt[0] = '{32'h0000_0006, 1, 0, 31'h3};
    vt[1] = '{32'h0000_0001, 0, 1, 31'h0};
    vt[2] = '{32'hFFFF_FFFE, 1, 0, 31'h7FFF_FFFF};
    vt[3] = '{32'h0000_0000, 1, 0, 31'h0};
    vt[4] = '{32'h8000_0001, 0, 1, 31'h0};
    vt[5] = '{32'h1234_5678, 1, 0, 31'h091A_2B3C};

    host_write_enable = 1'b0;
    host_data_out = '0;
    sig_ready = 1'b0;
    fill_rf(1);

    rst = 1'b1;
    repeat (3) begin
      tick();
      chk_quiet("rst", 1);
    end
    rst = 1'b0;
    // Writes while held in reset must be ignored.
    host_write_enable = 1'b1;
    host_data_out = 32'h1;
    tick();
    chk_quiet("hold1", 1);
    tick();
    host_write_enable = 1'b0;
    chk_quiet("run0", 0);
    tick();
    chk_quiet("run1", 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      fill_rf(0);
      host_write_enable = 1'b1;
      host_data_out = vt[i].data;
      tick();
      host_write_enable = 1'b0;
      chk($sformatf("vec%0d.done", i), done, vt[i].exp_done);
      chk($sformatf("vec%0d.pass", i), pass, vt[i].exp_pass);
      chk($sformatf("vec%0d.code", i), fail_code, vt[i].exp_code);
      chk($sformatf("vec%0d.halt", i), core_halt, 1);
      chk($sformatf("vec%0d.valid", i), sig_valid, 0);
      if (vt[i].exp_pass) begin
        run_dump(1);
      end else begin
        host_write_enable = 1'b1;
        host_data_out = 32'h1;
        sig_ready = 1'b1;
        cnt = 0;
        repeat (4) begin
          tick();
          host_write_enable = 1'b0;
          if (sig_valid || !done || pass) cnt++;
        end
        chk($sformatf("vec%0d.sticky", i), cnt, 0);
        chk($sformatf("vec%0d.code2", i), fail_code, vt[i].exp_code);
        sig_ready = 1'b0;
      end
    end

    do_reset();
    fill_rf(1);
    host_write_enable = 1'b1;
    host_data_out = 32'h1;
    tick();
    host_write_enable = 1'b0;
    run_dump(0);

    do_reset();
    fill_rf(0);
    host_write_enable = 1'b1;
    host_data_out = 32'hF0;
    tick();
    host_write_enable = 1'b0;
    chk("b0.nodone", done, 1);
    chk("b0.fail", pass, 0);

    do_reset();
    fill_rf(0);
    host_write_enable = 1'b1;
    host_data_out = 32'h3;
    tick();
    host_write_enable = 1'b0;
    run_dump(2);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      fill_rf(0);
      d = $urandom;
      code = d[XLEN-1:1];
      repeat ($urandom_range(0, 50)) tick();
      chk($sformatf("rnd%0d.idle", r), done, 0);
      host_write_enable = 1'b1;
      host_data_out = d;
      tick();
      host_write_enable = 1'b0;
      if (d[0]) begin
        run_dump(1);
      end else begin
        chk($sformatf("rnd%0d.done", r), done, 1);
        chk($sformatf("rnd%0d.pass", r), pass, 0);
        chk($sformatf("rnd%0d.code", r), fail_code, code);
      end
    end

    do_reset();
    fill_rf(1);
    host_write_enable = 1'b1;
    host_data_out = 32'h1;
    tick();
    host_write_enable = 1'b0;
    sig_ready = 1'b1;
    cnt = 0;
    while (!(sig_valid && sig_index == 10) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("mid.reached", sig_index, 10);
    rst = 1'b1;
    tick();
    chk("mid.sig_valid", sig_valid, 0);
    chk("mid.core_rst", core_rst, 1);
    chk("mid.done", done, 0);
    chk("mid.pass", pass, 0);
    chk("mid.halt", core_halt, 0);
    chk("mid.sig_data", sig_data, 0);
    rst = 1'b0;
    sig_ready = 1'b0;

`ifdef SIM_HARNESS_WATCHDOG_EN
    do_reset();
    cnt = 0;
    while (!done && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("wd.cycles", cnt, MAXC);
    chk("wd.timed_out", timed_out, 1);
    chk("wd.pass", pass, 0);
    chk("wd.halt", core_halt, 1);
    chk("wd.code", fail_code, 0);

    do_reset();
    fill_rf(0);
    repeat (MAXC - 1) tick();
    chk("wd99.idle", done, 0);
    host_write_enable = 1'b1;
    host_data_out = 32'h1;
    tick();
    host_write_enable = 1'b0;
    chk("wd99.timed_out", timed_out, 0);
    chk("wd99.pass", pass, 1);
    run_dump(0);
`else
    do_reset();
    repeat (3 * MAXC) tick();
    chk("nowd.done", done, 0);
    chk("nowd.timed_out", timed_out, 0);
    chk("nowd.core_rst", core_rst, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
